serial_adder8: RTL
==================

Name: serial_adder8

Overview:
- Bit-serial adder, the addition counterpart to the team's 8-bit ripple subtractor datapath.
- Latches two WIDTH-bit operands and a carry-in on a start pulse, then adds LSB-first, one bit per clock, through a single full-adder cell and a carry flop.
- Presents a registered sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, and as a sequential cross-check for the combinational subtract path.

Parameters:
- WIDTH, 8, operand and sum width in bits (must be >= 2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block is in IDLE or DONE.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- carryin  input  1  carry-in; sampled only on an accepted start.
- sum  output  WIDTH  registered result (a + b + carryin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.
- busy  output  1  high while an add is in progress (RUN).
- done  output  1  one-cycle pulse, high in the cycle the new sum/cout first become valid.

Behaviour:
- Reset (rst_n low, async): state=IDLE; sum=0, cout=0, busy=0, done=0; internal shift registers, carry flop and counter cleared.
- Release of reset is synchronous to clk.
- States: IDLE, RUN, DONE; encoding is free.
- IDLE:
  - start=1 at edge E0: load A/B shift regs with a/b, carry flop with carryin, cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - s = A[0]^B[0]^c; c <= maj(A[0],B[0],c).
  - A and B shift right; the result shift register shifts right with s entering at the MSB.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (edge E0+WIDTH): copy the completed result to sum, copy the final carry to cout, go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge: if start=1, behave as an IDLE accept (back-to-back op, new RUN); otherwise go to IDLE.
- busy = (state==RUN).
- start while in RUN is ignored; no queueing.
- Latency: start sampled at E0 -> done high during the cycle after E0+WIDTH.
  - Minimum start-to-start spacing: WIDTH+1 cycles.
- sum/cout change only on the completion edge. They hold their last value through IDLE, through the next RUN, and until the next completion; no partial results are ever visible.
- a, b and carryin may change freely after the accepting edge without affecting the operation in flight.
- Overflow: wraps mod 2^WIDTH. Carry is reported only on cout; there is no signed-overflow flag.
- Reset asserted mid-RUN: aborts immediately; all outputs return to reset values; no done pulse.
- X on start while in RUN has no effect.

Test Plan:
- Basic add: a=8'h3C, b=8'h05, cin=0, start 1 cycle -> done exactly 9 cycles after the start edge (done visible in the cycle after edge E0+8); sum=8'h41, cout=0; busy high for 8 cycles.
- Wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start: start with a=8'h10, b=8'h20; pulse start again mid-RUN with a=8'hAA -> single done, sum=8'h30; no second done.
- Back-to-back: hold start high through DONE with a=8'h01, b=8'h01 after a first op of 8'h80+8'h80 -> first done gives sum=8'h00, cout=1; second done gives sum=8'h02, cout=0, 9 cycles later; sum holds 8'h00 in between.
- Async reset: assert rst_n=0 at cycle 4 of RUN (not on a clock edge) -> sum=0, cout=0, busy=0 immediately; no done; a fresh start afterwards computes correctly.
- Random: 1000 random a, b, cin with random idle gaps -> {cout,sum} == a+b+cin at every done, checked against a reference model.

Source files
------------

// File: rtl/serial_adder8.sv
// rtl/serial_adder8.sv - bit-serial LSB-first adder with registered sum/cout and done pulse
module serial_adder8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // Holds the first WIDTH-1 sum bits; the last bit joins them on the completion edge.
  logic [WIDTH-2:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               s_bit;
  logic               c_next;
  logic [WIDTH-1:0]   res_shift;

  assign s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign res_shift = {s_bit, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start == 1'b1) begin
          a_d     = a;
          b_d     = b;
          carry_d = carryin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift[WIDTH-1:1];
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_shift;
          cout_d  = c_next;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule
